// File: rtl/hpdcache_pkg.sv
// hpdcache_pkg: shared HPDcache widths plus the tracker entry-state and request-op enums.
package hpdcache_pkg;
    localparam int HPDCACHE_PA_WIDTH       = 49;
    localparam int HPDCACHE_WORD_WIDTH     = 64;
    localparam int HPDCACHE_TRANS_ID_WIDTH = 7;
    localparam int HPDCACHE_SRC_ID_WIDTH   = 3;

    typedef enum logic [1:0] {ENTRY_IDLE, ENTRY_PEND, ENTRY_DONE} hpdcache_entry_state_e;
    typedef enum logic {HPDCACHE_LOAD, HPDCACHE_STORE} hpdcache_req_op_e;
endpackage

// File: rtl/hpdcache_req_tracker_timer.sv
// hpdcache_req_tracker_timer: saturating wait counter for a pending head entry with a sticky timeout flag.
module hpdcache_req_tracker_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic head_pend_i,
    output logic timeout_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    always_comb begin
        cnt_d     = !head_pend_i ? '0 : (cnt_q == LIMIT) ? cnt_q : cnt_q + CW'(1);
        timeout_d = timeout_q | (cnt_d == LIMIT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
endmodule

// File: rtl/hpdcache_req_tracker.sv
// hpdcache_req_tracker: issues client requests with table-slot transaction IDs, returns responses in order.
// Optional head timeout watchdog enabled by HPDCACHE_REQ_TRACKER_TIMEOUT_EN.
module hpdcache_req_tracker
    import hpdcache_pkg::*;
#(
    parameter int ENTRIES        = 8,
    parameter int TRANS_ID_WIDTH = HPDCACHE_TRANS_ID_WIDTH,
    parameter int SRC_ID_WIDTH   = HPDCACHE_SRC_ID_WIDTH,
    parameter int SRC_ID         = 0,
    parameter int ADDR_WIDTH     = HPDCACHE_PA_WIDTH,
    parameter int DATA_WIDTH     = HPDCACHE_WORD_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      creq_valid_i,
    output logic                      creq_ready_o,
    input  hpdcache_req_op_e          creq_op_i,
    input  logic [ADDR_WIDTH-1:0]     creq_addr_i,
    input  logic [DATA_WIDTH-1:0]     creq_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   creq_be_i,
    output logic                      crsp_valid_o,
    input  logic                      crsp_ready_i,
    output logic [DATA_WIDTH-1:0]     crsp_rdata_o,
    output logic                      crsp_error_o,
    output logic                      core_req_valid_o,
    input  logic                      core_req_ready_i,
    output hpdcache_req_op_e          core_req_op_o,
    output logic [ADDR_WIDTH-1:0]     core_req_addr_o,
    output logic [DATA_WIDTH-1:0]     core_req_wdata_o,
    output logic [DATA_WIDTH/8-1:0]   core_req_be_o,
    output logic [SRC_ID_WIDTH-1:0]   core_req_sid_o,
    output logic [TRANS_ID_WIDTH-1:0] core_req_tid_o,
    input  logic                      core_rsp_valid_i,
    input  logic [SRC_ID_WIDTH-1:0]   core_rsp_sid_i,
    input  logic [TRANS_ID_WIDTH-1:0] core_rsp_tid_i,
    input  logic [DATA_WIDTH-1:0]     core_rsp_rdata_i,
    input  logic                      core_rsp_error_i,
    output logic                      busy_o,
    output logic                      stray_o,
    output logic                      timeout_o
);
    localparam int PTR_W = $clog2(ENTRIES);
    localparam logic [PTR_W:0]          FULL_CNT = (PTR_W + 1)'(ENTRIES);
    localparam logic [TRANS_ID_WIDTH:0] TID_LIM  = (TRANS_ID_WIDTH + 1)'(ENTRIES);
    localparam logic [SRC_ID_WIDTH-1:0] MY_SID   = SRC_ID_WIDTH'(SRC_ID);

    hpdcache_entry_state_e state_q [ENTRIES];
    hpdcache_entry_state_e state_d [ENTRIES];
    hpdcache_req_op_e      op_q    [ENTRIES];
    hpdcache_req_op_e      op_d    [ENTRIES];
    logic [DATA_WIDTH-1:0] rdata_q [ENTRIES];
    logic [DATA_WIDTH-1:0] rdata_d [ENTRIES];
    logic                  err_q   [ENTRIES];
    logic                  err_d   [ENTRIES];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, rsp_idx;
    logic [PTR_W:0]   count_q, count_d;
    logic             stray_q, stray_d;
    logic             full, alloc, pop, rsp_hit;

    assign full             = (count_q == FULL_CNT);
    assign core_req_valid_o = creq_valid_i & !full;
    assign creq_ready_o     = core_req_ready_i & !full;
    assign core_req_op_o    = creq_op_i;
    assign core_req_addr_o  = creq_addr_i;
    assign core_req_wdata_o = creq_wdata_i;
    assign core_req_be_o    = creq_be_i;
    assign core_req_sid_o   = MY_SID;
    assign core_req_tid_o   = TRANS_ID_WIDTH'(tail_q);
    assign alloc            = core_req_valid_o & core_req_ready_i;

    assign crsp_valid_o = (state_q[head_q] == ENTRY_DONE);
    assign crsp_rdata_o = rdata_q[head_q];
    assign crsp_error_o = err_q[head_q];
    assign pop          = crsp_valid_o & crsp_ready_i;

    // The head entry is DONE when popped, so a same-cycle response to it falls out as stray here.
    assign rsp_idx = core_rsp_tid_i[PTR_W-1:0];
    assign rsp_hit = core_rsp_valid_i && (core_rsp_sid_i == MY_SID) &&
                     ({1'b0, core_rsp_tid_i} < TID_LIM) && (state_q[rsp_idx] == ENTRY_PEND);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (alloc) begin
            state_d[tail_q] = ENTRY_PEND;
            op_d[tail_q]    = creq_op_i;
        end
        if (rsp_hit) begin
            state_d[rsp_idx] = ENTRY_DONE;
            rdata_d[rsp_idx] = (op_q[rsp_idx] == HPDCACHE_STORE) ? '0 : core_rsp_rdata_i;
            err_d[rsp_idx]   = core_rsp_error_i;
        end
        if (pop)
            state_d[head_q] = ENTRY_IDLE;
        tail_d  = alloc ? tail_q + PTR_W'(1) : tail_q;
        head_d  = pop ? head_q + PTR_W'(1) : head_q;
        count_d = (alloc && !pop) ? count_q + (PTR_W + 1)'(1) :
                  (pop && !alloc) ? count_q - (PTR_W + 1)'(1) : count_q;
        stray_d = core_rsp_valid_i & !rsp_hit;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                state_q[i] <= ENTRY_IDLE;
                op_q[i]    <= HPDCACHE_LOAD;
                rdata_q[i] <= '0;
                err_q[i]   <= 1'b0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            stray_q <= stray_d;
        end
    end

    assign busy_o  = (count_q != '0);
    assign stray_o = stray_q;

`ifdef HPDCACHE_REQ_TRACKER_TIMEOUT_EN
    hpdcache_req_tracker_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .head_pend_i(state_q[head_q] == ENTRY_PEND),
        .timeout_o  (timeout_o)
    );
`else
    assign timeout_o = (TIMEOUT_CYCLES < 0);
`endif
endmodule
